// File: rtl/pe_inject_ni.sv
// pe_inject_ni: PE-to-router injection NI; queues PE words, sends credit-gated flits.
// Optional NI_FLIT_COUNT_EN adds sent_cnt (16b wrapping count of issued flits).
// Ports: clk, rst (async, active-low).
// PE side: req_valid/req_ready/req_dest/req_data.
// Router side: ci, dataout, out_valid.
// Status: state, credit_cnt, credit_err[, sent_cnt].
module pe_inject_ni #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_dest,
  input  logic [15:0] req_data,
  input  logic        ci,
  output logic [19:0] dataout,
  output logic        out_valid,
  output logic [1:0]  state,
  output logic [2:0]  credit_cnt,
  output logic        credit_err
`ifdef NI_FLIT_COUNT_EN
  ,
  output logic [15:0] sent_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  L_CRED = 3'(CREDITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [19:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_credit;
  logic          r_err;
  logic [19:0]   r_dout;
  logic          r_oval;
  state_t        r_state;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;
  logic [2:0]    w_credit_nxt;
  logic          w_err_set;
  state_t        w_state_nxt;

  assign req_ready = (r_count != L_FULL);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_count != '0) && (r_credit != 3'd0);

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // A returned credit and a spent credit cancel; a return
  // with the counter already at its ceiling is an overflow.
  always_comb begin
    w_credit_nxt = r_credit;
    w_err_set    = 1'b0;
    unique case ({ci, w_pop})
      2'b01: w_credit_nxt = r_credit - 1'b1;
      2'b10: begin
        if (r_credit == L_CRED) begin
          w_err_set = 1'b1;
        end else begin
          w_credit_nxt = r_credit + 1'b1;
        end
      end
      default: w_credit_nxt = r_credit;
    endcase
  end

  // State tracks post-edge occupancy and credits so it
  // reflects what the next cycle will do.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_count_nxt != '0) begin
          if (w_credit_nxt != 3'd0) w_state_nxt = S_SEND;
          else                      w_state_nxt = S_WAIT;
        end
      end
      S_SEND: begin
        if (w_count_nxt == '0)        w_state_nxt = S_IDLE;
        else if (w_credit_nxt == 3'd0) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_count_nxt == '0)        w_state_nxt = S_IDLE;
        else if (w_credit_nxt != 3'd0) w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_dest, req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_credit <= L_CRED;
      r_err    <= 1'b0;
      r_dout   <= '0;
      r_oval   <= 1'b0;
      r_state  <= S_IDLE;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_nxt;
      r_credit <= w_credit_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_pop) r_dout <= r_mem[r_rptr];
      r_oval   <= w_pop;
      r_state  <= w_state_nxt;
    end
  end

`ifdef NI_FLIT_COUNT_EN
  logic [15:0] r_sent;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sent <= '0;
    end else if (w_pop) begin
      r_sent <= r_sent + 1'b1;
    end
  end

  assign sent_cnt = r_sent;
`endif

  assign dataout    = r_dout;
  assign out_valid  = r_oval;
  assign state      = r_state;
  assign credit_cnt = r_credit;
  assign credit_err = r_err;

endmodule

// File: tb/tb_pe_inject_ni.sv
// tb_pe_inject_ni: directed bench for pe_inject_ni with a flit scoreboard.
// Expected flits are queued on acceptance and checked in order on out_valid.
module tb_pe_inject_ni;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dest;
  logic [15:0] req_data;
  logic        ci;
  logic [19:0] dataout;
  logic        out_valid;
  logic [1:0]  state;
  logic [2:0]  credit_cnt;
  logic        credit_err;
`ifdef NI_FLIT_COUNT_EN
  logic [15:0] sent_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int nflit = 0;
  int n0;
  logic [19:0] q[$];

  pe_inject_ni #(.FIFO_DEPTH(4), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_data   (req_data),
    .ci         (ci),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .state      (state),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
`ifdef NI_FLIT_COUNT_EN
    ,
    .sent_cnt   (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit v, logic [3:0] d, logic [15:0] x, bit c);
    logic        acc;
    logic [19:0] e;
    @(negedge clk);
    req_valid = v;
    req_dest  = d;
    req_data  = x;
    ci        = c;
    acc       = v && (req_ready === 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ci        = 1'b0;
    if (acc) q.push_back({d, x});
    if (out_valid === 1'b1) begin
      nflit++;
      if (q.size() == 0) begin
        chk("spurious_flit", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("flit", 32'(dataout), 32'(e));
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, 16'h0, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_dest  = 4'h0;
    req_data  = 16'h0;
    ci        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dataout), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_credit", 32'(credit_cnt), 32'd4);
    chk("rst_err", 32'(credit_err), 32'd0);
`ifdef NI_FLIT_COUNT_EN
    chk("rst_sent", 32'(sent_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // single word, one-cycle latency
    cyc(1'b1, 4'b0110, 16'hBEEF, 1'b0);
    chk("lat_novalid", 32'(out_valid), 32'd0);
    chk("lat_credit4", 32'(credit_cnt), 32'd4);
    cyc(1'b0, 4'h0, 16'h0, 1'b0);
    chk("beef_valid", 32'(out_valid), 32'd1);
    chk("beef_dout", 32'(dataout), 32'h6BEEF);
    chk("beef_credit", 32'(credit_cnt), 32'd3);
    cyc(1'b0, 4'h0, 16'h0, 1'b0);
    chk("pulse_low", 32'(out_valid), 32'd0);
    chk("hold_dout", 32'(dataout), 32'h6BEEF);
    chk("idle_state", 32'(state), 32'd0);
    cyc(1'b0, 4'h0, 16'h0, 1'b1);
    chk("ret_credit", 32'(credit_cnt), 32'd4);

    // 6 words, 4 credits
    n0 = nflit;
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 4'(i + 1), 16'h1000 + 16'(i), 1'b0);
    idle(3);
    chk("burst_nflit", 32'(nflit - n0), 32'd4);
    chk("burst_state", 32'(state), 32'd2);
    chk("burst_credit", 32'(credit_cnt), 32'd0);
    cyc(1'b0, 4'h0, 16'h0, 1'b1);
    idle(2);
    chk("ci1_state", 32'(state), 32'd2);
    chk("ci1_nflit", 32'(nflit - n0), 32'd5);
    cyc(1'b0, 4'h0, 16'h0, 1'b1);
    idle(2);
    chk("ci2_state", 32'(state), 32'd0);
    chk("ci2_nflit", 32'(nflit - n0), 32'd6);
    chk("ci2_credit", 32'(credit_cnt), 32'd0);

    // fill FIFO with router held off
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'hC - 4'(i), 16'hA000 + 16'(i), 1'b0);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_state", 32'(state), 32'd2);
    cyc(1'b1, 4'hF, 16'hDEAD, 1'b0);
    chk("fifth_ready", 32'(req_ready), 32'd0);
    chk("fifth_q", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'h0, 16'h0, 1'b1);
      idle(1);
    end
    idle(2);
    chk("drain_q", 32'(q.size()), 32'd0);
    chk("drain_credit", 32'(credit_cnt), 32'd0);
    chk("drain_state", 32'(state), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 16'h0, 1'b1);
    chk("refill_credit", 32'(credit_cnt), 32'd4);
    chk("refill_ready", 32'(req_ready), 32'd1);

    // ci with issue, then overflow
    cyc(1'b1, 4'hA, 16'h5555, 1'b0);
    cyc(1'b0, 4'h0, 16'h0, 1'b1);
    chk("ci_issue_valid", 32'(out_valid), 32'd1);
    chk("ci_issue_credit", 32'(credit_cnt), 32'd4);
    chk("ci_issue_err", 32'(credit_err), 32'd0);
    cyc(1'b0, 4'h0, 16'h0, 1'b1);
    chk("ovf_credit", 32'(credit_cnt), 32'd4);
    chk("ovf_err", 32'(credit_err), 32'd1);
    idle(3);
    chk("ovf_sticky", 32'(credit_err), 32'd1);

    // reset with 3 words queued
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 4'(i), 16'h2000 + 16'(i), 1'b0);
    idle(1);
    chk("pre_rst_state", 32'(state), 32'd2);
    chk("pre_rst_credit", 32'(credit_cnt), 32'd0);
    chk("pre_rst_q", 32'(q.size()), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_credit", 32'(credit_cnt), 32'd4);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_err", 32'(credit_err), 32'd0);
    chk("mid_rst_dout", 32'(dataout), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    n0 = nflit;
    idle(6);
    chk("no_stale", 32'(nflit - n0), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);

`ifdef NI_FLIT_COUNT_EN
    chk("cnt_zero", 32'(sent_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'(i), 16'h3000 + 16'(i), 1'b0);
      cyc(1'b0, 4'h0, 16'h0, 1'b1);
    end
    idle(2);
    chk("cnt_ten", 32'(sent_cnt), 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
